// File: rtl/alu_muldiv_pipe.sv
// Execute-stage ALU: RV32I integer ops in one cycle, M-subset mul/div via an
// XLEN-step iterative engine, valid/ready handshakes on both sides.
module alu_muldiv_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLL   = 5'd2;
  localparam logic [4:0] OP_SLT   = 5'd3;
  localparam logic [4:0] OP_SLTU  = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_OR    = 5'd8;
  localparam logic [4:0] OP_AND   = 5'd9;
  localparam logic [4:0] OP_MUL   = 5'd10;
  localparam logic [4:0] OP_MULHU = 5'd11;
  localparam logic [4:0] OP_DIV   = 5'd12;
  localparam logic [4:0] OP_DIVU  = 5'd13;
  localparam logic [4:0] OP_REM   = 5'd14;
  localparam logic [4:0] OP_REMU  = 5'd15;

  typedef enum logic {IDLE, ITER} state_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [4:0]         op_q, op_d;
  logic [XLEN-1:0]    hi_q, hi_d;
  logic [XLEN-1:0]    lo_q, lo_d;
  logic [XLEN-1:0]    opnd_q, opnd_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               valid_q, valid_d;
  logic [XLEN-1:0]    res_q, res_d;
  logic [TAG_W-1:0]   otag_q, otag_d;
  logic               ill_q, ill_d;

  logic               accept;
  logic               op_iter;
  logic               op_mul;
  logic               op_signed;
  logic               a_neg, b_neg;
  logic [XLEN-1:0]    a_mag, b_mag;
  logic [SHW-1:0]     shamt;
  logic [XLEN-1:0]    alu_res;
  logic [XLEN:0]      mul_sum;
  logic [XLEN:0]      div_shift;
  logic [XLEN:0]      div_diff;
  logic [XLEN-1:0]    hi_n, lo_n;
  logic [XLEN-1:0]    iter_res;

  assign in_ready    = rst_n & (state_q == IDLE) & (~valid_q | out_ready);
  assign accept      = in_valid & in_ready;
  assign out_valid   = valid_q;
  assign out_result  = res_q;
  assign out_tag     = otag_q;
  assign out_illegal = ill_q;

  // Single-cycle integer ops
  always_comb begin
    shamt   = in_b[SHW-1:0];
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_SLL:  alu_res = in_a << shamt;
      OP_SLT:  alu_res = XLEN'($signed(in_a) < $signed(in_b));
      OP_SLTU: alu_res = XLEN'(in_a < in_b);
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(in_a) >>> shamt);
      OP_OR:   alu_res = in_a | in_b;
      OP_AND:  alu_res = in_a & in_b;
      default: alu_res = '0;
    endcase
  end

  // Operand preparation for the iterative engine (signed div works on magnitudes)
  always_comb begin
    op_iter   = (in_op >= OP_MUL) && (in_op <= OP_REMU);
    op_mul    = (in_op == OP_MUL) || (in_op == OP_MULHU);
    op_signed = (in_op == OP_DIV) || (in_op == OP_REM);
    a_neg     = op_signed & in_a[XLEN-1];
    b_neg     = op_signed & in_b[XLEN-1];
    a_mag     = a_neg ? (~in_a + 1'b1) : in_a;
    b_mag     = b_neg ? (~in_b + 1'b1) : in_b;
  end

  // One shift-add or restoring shift-subtract step
  always_comb begin
    mul_sum   = {1'b0, hi_q} + ({1'b0, opnd_q} & {(XLEN+1){lo_q[0]}});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      hi_n = div_diff[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_n = div_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], 1'b0};
    end
    case (op_q)
      OP_MUL:           iter_res = lo_n;
      OP_MULHU:         iter_res = hi_n;
      OP_DIV, OP_DIVU:  iter_res = neg_quo_q ? (~lo_n + 1'b1) : lo_n;
      default:          iter_res = neg_rem_q ? (~hi_n + 1'b1) : hi_n;
    endcase
  end

  // Next-state and output-register logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    res_d     = res_q;
    otag_d    = otag_q;
    ill_d     = ill_q;

    if (valid_q && out_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_iter) begin
            state_d   = ITER;
            cnt_d     = '0;
            op_d      = in_op;
            tag_d     = in_tag;
            hi_d      = '0;
            lo_d      = op_mul ? in_a : a_mag;
            opnd_d    = op_mul ? in_b : b_mag;
            // Divide-by-zero must yield -1, so the quotient is never negated then
            neg_quo_d = (a_neg ^ b_neg) & (in_b != '0);
            neg_rem_d = a_neg;
          end else begin
            valid_d = 1'b1;
            res_d   = alu_res;
            otag_d  = in_tag;
            ill_d   = in_op[4];
          end
        end
      end
      ITER: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          valid_d = 1'b1;
          res_d   = iter_res;
          otag_d  = tag_q;
          ill_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      res_q     <= '0;
      otag_q    <= '0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      res_q     <= res_d;
      otag_q    <= otag_d;
      ill_q     <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_pipe.sv
// Directed bench for alu_muldiv_pipe at XLEN=32 and XLEN=16.
module tb_alu_muldiv_pipe;

  logic        clk;
  logic        rst_n;
  logic [4:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        iv32, ir32, ov32, oi32;
  logic [31:0] a32, b32, r32;
  logic [4:0]  t32;

  logic        iv16, ir16, ov16, oi16;
  logic [15:0] a16, b16, r16;
  logic [4:0]  t16;

  int checks;
  int failures;

  alu_muldiv_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv32), .in_ready(ir32), .in_op(in_op), .in_a(a32), .in_b(b32), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_result(r32), .out_tag(t32), .out_illegal(oi32)
  );

  alu_muldiv_pipe #(.XLEN(16), .TAG_W(5)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16), .in_op(in_op), .in_a(a16), .in_b(b16), .in_tag(in_tag),
    .out_valid(ov16), .out_ready(out_ready), .out_result(r16), .out_tag(t16), .out_illegal(oi16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Issue one op, then measure edges after the accepting edge until out_valid.
  task automatic run(input bit h, input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] tag, input logic [63:0] exp, input logic exp_ill,
                     input int exp_lat, input string name);
    int lat;
    bit rdy_seen;
    @(negedge clk);
    in_op     = op;
    in_tag    = tag;
    out_ready = 1'b1;
    if (h) begin a16 = a[15:0]; b16 = b[15:0]; iv16 = 1'b1; end
    else   begin a32 = a[31:0]; b32 = b[31:0]; iv32 = 1'b1; end
    #1;
    chk({name, "_in_ready"}, 64'(h ? ir16 : ir32), 64'd1);
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    iv32 = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    while (!(h ? ov16 : ov32) && lat < 200) begin
      if (h ? ir16 : ir32) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_result"}, h ? 64'(r16) : 64'(r32), exp);
    chk({name, "_tag"}, 64'(h ? t16 : t32), 64'(tag));
    chk({name, "_illegal"}, 64'(h ? oi16 : oi32), 64'(exp_ill));
    if (exp_lat > 0) chk({name, "_busy_ready"}, 64'(rdy_seen), 64'd0);
  endtask

  initial begin
    bit stale;
    checks = 0; failures = 0;
    rst_n = 1'b0; out_ready = 1'b1;
    in_op = '0; in_tag = '0;
    iv32 = 1'b0; a32 = '0; b32 = '0;
    iv16 = 1'b0; a16 = '0; b16 = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ir32), 64'd0);
    chk("rst_out_valid", 64'(ov32), 64'd0);
    chk("rst_out_result", 64'(r32), 64'd0);
    chk("rst_out_tag", 64'(t32), 64'd0);
    chk("rst_out_illegal", 64'(oi32), 64'd0);
    chk("rst_out_valid16", 64'(ov16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle ops
    run(0, 5'd0, 64'hFFFF_FFFF, 64'd1, 5'd1, 64'h0000_0000, 1'b0, 0, "add_wrap");
    run(0, 5'd1, 64'd0, 64'd1, 5'd2, 64'hFFFF_FFFF, 1'b0, 0, "sub_wrap");
    run(0, 5'd7, 64'h8000_0000, 64'h21, 5'd3, 64'hC000_0000, 1'b0, 0, "sra");
    run(0, 5'd3, 64'hFFFF_FFFF, 64'd0, 5'd4, 64'd1, 1'b0, 0, "slt");
    run(0, 5'd4, 64'hFFFF_FFFF, 64'd0, 5'd5, 64'd0, 1'b0, 0, "sltu");
    run(0, 5'd2, 64'h0000_0001, 64'h24, 5'd6, 64'h0000_0010, 1'b0, 0, "sll");
    run(0, 5'd9, 64'hF0F0_F0F0, 64'h0FF0_0FF0, 5'd7, 64'h00F0_00F0, 1'b0, 0, "and");

    // Back-to-back ADDs with a 3-cycle downstream stall before the 5th
    in_op = 5'd0; b32 = 32'd100; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      iv32 = 1'b1; a32 = 32'(i); in_tag = 5'(i);
      if (i == 4) begin
        out_ready = 1'b0;
        repeat (3) begin
          #1;
          chk("stall_in_ready", 64'(ir32), 64'd0);
          @(posedge clk);
          #1;
          chk("stall_valid", 64'(ov32), 64'd1);
          chk("stall_tag", 64'(t32), 64'd3);
          chk("stall_result", 64'(r32), 64'd103);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("burst_valid", 64'(ov32), 64'd1);
      chk("burst_tag", 64'(t32), 64'(i));
      chk("burst_result", 64'(r32), 64'(100 + i));
    end
    @(negedge clk);
    iv32 = 1'b0;
    @(posedge clk);
    #1;
    chk("burst_drain", 64'(ov32), 64'd0);

    // Iterative ops, XLEN=32
    run(0, 5'd10, 64'h1234_5678, 64'h9ABC_DEF0, 5'd8, 64'h242D_2080, 1'b0, 32, "mul");
    run(0, 5'd11, 64'h1234_5678, 64'h9ABC_DEF0, 5'd9, 64'h0B00_EA4E, 1'b0, 32, "mulhu");
    run(0, 5'd12, 64'hFFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFD, 1'b0, 32, "div_neg");
    run(0, 5'd14, 64'hFFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF, 1'b0, 32, "rem_neg");
    run(0, 5'd13, 64'd7, 64'd0, 5'd12, 64'hFFFF_FFFF, 1'b0, 32, "divu_by0");
    run(0, 5'd14, 64'd7, 64'd0, 5'd13, 64'd7, 1'b0, 32, "rem_by0");
    run(0, 5'd12, 64'd7, 64'd0, 5'd14, 64'hFFFF_FFFF, 1'b0, 32, "div_by0");
    run(0, 5'd12, 64'h8000_0000, 64'hFFFF_FFFF, 5'd15, 64'h8000_0000, 1'b0, 32, "div_ovf");
    run(0, 5'd14, 64'h8000_0000, 64'hFFFF_FFFF, 5'd16, 64'd0, 1'b0, 32, "rem_ovf");
    run(0, 5'd15, 64'd100, 64'd7, 5'd17, 64'd2, 1'b0, 32, "remu");

    // Illegal op, then a legal op clears the flag
    run(0, 5'd20, 64'd5, 64'd6, 5'd18, 64'd0, 1'b1, 0, "illegal");
    run(0, 5'd0, 64'd5, 64'd6, 5'd19, 64'd11, 1'b0, 0, "add_after_ill");

    // Reset in the middle of a DIVU abandons it
    @(negedge clk);
    in_op = 5'd13; a32 = 32'd100; b32 = 32'd7; in_tag = 5'd20; iv32 = 1'b1;
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(ov32), 64'd0);
    chk("midrst_in_ready", 64'(ir32), 64'd0);
    chk("midrst_result", 64'(r32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ov32) stale = 1'b1;
    end
    chk("midrst_no_stale", 64'(stale), 64'd0);
    chk("midrst_idle_ready", 64'(ir32), 64'd1);
    run(0, 5'd0, 64'd40, 64'd2, 5'd21, 64'd42, 1'b0, 0, "add_after_rst");

    // XLEN=16 instance
    run(1, 5'd0, 64'hFFFF, 64'd1, 5'd1, 64'h0000, 1'b0, 0, "x16_add_wrap");
    run(1, 5'd7, 64'h8000, 64'h11, 5'd2, 64'hC000, 1'b0, 0, "x16_sra");
    run(1, 5'd10, 64'h1234, 64'h5678, 5'd3, 64'h0060, 1'b0, 16, "x16_mul");
    run(1, 5'd11, 64'h1234, 64'h5678, 5'd4, 64'h0626, 1'b0, 16, "x16_mulhu");
    run(1, 5'd12, 64'hFFF9, 64'd2, 5'd5, 64'hFFFD, 1'b0, 16, "x16_div_neg");
    run(1, 5'd14, 64'hFFF9, 64'd2, 5'd6, 64'hFFFF, 1'b0, 16, "x16_rem_neg");
    run(1, 5'd12, 64'h8000, 64'hFFFF, 5'd7, 64'h8000, 1'b0, 16, "x16_div_ovf");
    run(1, 5'd13, 64'd7, 64'd0, 5'd8, 64'hFFFF, 1'b0, 16, "x16_divu_by0");
    run(1, 5'd31, 64'd1, 64'd1, 5'd9, 64'd0, 1'b1, 0, "x16_illegal");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
